// File: rtl/alu_status_unit.sv
// Status register, flag-based branch resolution, overflow trap handshake and
// saturating overflow event counter sitting behind the 32-bit ALU.
module alu_status_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] alu_sum,
   input  logic        zout,
   input  logic        nout,
   input  logic        overflow,
   input  logic        flag_we,
   input  logic        ovf_en,
   input  logic [31:0] pc,
   input  logic        br_en,
   input  logic [2:0]  cond,
   input  logic        trap_ack,
   output logic [2:0]  status,
   output logic [31:0] last_sum,
   output logic        branch_taken,
   output logic        trap_req,
   output logic [31:0] epc,
   output logic [7:0]  ovf_cnt
);

   typedef enum logic {
      TRAP_IDLE,
      TRAP_PEND
   } trap_state_t;

   trap_state_t state;
   trap_state_t state_next;

   logic flag_z;
   logic flag_n;
   logic flag_v;
   logic cond_true;
   logic ovf_evt;

   // Overflow only matters for signed arithmetic that also writes the flags.
   assign ovf_evt = flag_we & ovf_en & overflow;

   assign status = {flag_v, flag_n, flag_z};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z   <= 1'b0;
         flag_n   <= 1'b0;
         flag_v   <= 1'b0;
         last_sum <= 32'd0;
      end else if (flag_we) begin
         flag_z   <= zout;
         flag_n   <= nout;
         flag_v   <= overflow & ovf_en;
         last_sum <= alu_sum;
      end
   end

   // Branch decisions look only at the registered flags, never at this cycle's ALU flags.
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         3'b000:  cond_true = 1'b0;
         3'b001:  cond_true = flag_z;
         3'b010:  cond_true = ~flag_z;
         3'b011:  cond_true = flag_n;
         3'b100:  cond_true = ~flag_n;
         3'b101:  cond_true = flag_v;
         3'b110:  cond_true = flag_n ^ flag_v;
         default: cond_true = 1'b1;
      endcase
   end

   assign branch_taken = br_en & cond_true & ~trap_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= TRAP_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // trap_req decodes straight from the state so an async reset drops it at once.
   always_comb begin
      state_next = state;
      trap_req   = 1'b0;
      case (state)
         TRAP_IDLE: begin
            if (ovf_evt) begin
               state_next = TRAP_PEND;
            end
         end
         TRAP_PEND: begin
            trap_req = 1'b1;
            if (trap_ack) begin
               state_next = TRAP_IDLE;
            end
         end
         default: state_next = TRAP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epc <= 32'd0;
      end else if ((state == TRAP_IDLE) && ovf_evt) begin
         epc <= pc;
      end
   end

   // Counts every qualified event regardless of trap state; sticks at the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt <= 8'd0;
      end else if (ovf_evt && (ovf_cnt != 8'hFF)) begin
         ovf_cnt <= ovf_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_alu_status_unit.sv
// Self-checking bench for alu_status_unit: directed vectors, a branch-condition
// table and randomized traffic compared against a behavioural model.
module tb_alu_status_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] alu_sum;
   logic        zout;
   logic        nout;
   logic        overflow;
   logic        flag_we;
   logic        ovf_en;
   logic [31:0] pc;
   logic        br_en;
   logic [2:0]  cond;
   logic        trap_ack;
   logic [2:0]  status;
   logic [31:0] last_sum;
   logic        branch_taken;
   logic        trap_req;
   logic [31:0] epc;
   logic [7:0]  ovf_cnt;

   int checks;
   int failures;

   // Behavioural model state
   bit          mz, mn, mv;
   logic [31:0] msum;
   bit          mpend;
   logic [31:0] mepc;
   int          mcnt;

   typedef struct {
      logic        flag_we;
      logic        zout;
      logic        nout;
      logic        overflow;
      logic        ovf_en;
      logic [31:0] alu_sum;
      logic [31:0] pc;
      logic        br_en;
      logic [2:0]  cond;
      logic        trap_ack;
   } stim_t;

   typedef struct {
      logic [2:0] cond;
      logic       flag_we;
      logic       zout;
      logic       clock_after;
      logic       exp_taken;
   } br_vec_t;

   alu_status_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_sum      (alu_sum),
      .zout         (zout),
      .nout         (nout),
      .overflow     (overflow),
      .flag_we      (flag_we),
      .ovf_en       (ovf_en),
      .pc           (pc),
      .br_en        (br_en),
      .cond         (cond),
      .trap_ack     (trap_ack),
      .status       (status),
      .last_sum     (last_sum),
      .branch_taken (branch_taken),
      .trap_req     (trap_req),
      .epc          (epc),
      .ovf_cnt      (ovf_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit condHolds(input logic [2:0] c, input bit z, input bit n, input bit v);
      case (c)
         3'd0: return 1'b0;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return n;
         3'd4: return !n;
         3'd5: return v;
         3'd6: return n != v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit modelBranch();
      return br_en && !mpend && condHolds(cond, mz, mn, mv);
   endfunction

   task automatic modelReset();
      mz = 0; mn = 0; mv = 0;
      msum = 32'd0;
      mpend = 0;
      mepc = 32'd0;
      mcnt = 0;
   endtask

   task automatic modelEdge();
      bit evt;
      evt = flag_we && ovf_en && overflow;
      if (flag_we) begin
         mz = zout;
         mn = nout;
         mv = overflow && ovf_en;
         msum = alu_sum;
      end
      if (!mpend) begin
         if (evt) begin
            mpend = 1;
            mepc = pc;
         end
      end else if (trap_ack) begin
         mpend = 0;
      end
      if (evt) mcnt = (mcnt >= 255) ? 255 : mcnt + 1;
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ".status"}, {29'd0, status}, {29'd0, mv, mn, mz});
      checkVal({tag, ".last_sum"}, last_sum, msum);
      checkVal({tag, ".trap_req"}, {31'd0, trap_req}, {31'd0, mpend});
      checkVal({tag, ".epc"}, epc, mepc);
      checkVal({tag, ".ovf_cnt"}, {24'd0, ovf_cnt}, mcnt);
      checkVal({tag, ".branch"}, {31'd0, branch_taken}, {31'd0, modelBranch()});
   endtask

   task automatic applyStimulus(input stim_t s);
      flag_we  = s.flag_we;
      zout     = s.zout;
      nout     = s.nout;
      overflow = s.overflow;
      ovf_en   = s.ovf_en;
      alu_sum  = s.alu_sum;
      pc       = s.pc;
      br_en    = s.br_en;
      cond     = s.cond;
      trap_ack = s.trap_ack;
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
   endtask

   function automatic stim_t mk(input logic fwe, input logic z, input logic n, input logic ov,
                                input logic oen, input logic [31:0] p, input logic ack);
      stim_t s;
      s.flag_we = fwe; s.zout = z; s.nout = n; s.overflow = ov; s.ovf_en = oen;
      s.alu_sum = p ^ 32'hA5A5_0000; s.pc = p; s.br_en = 1'b1; s.cond = 3'd7; s.trap_ack = ack;
      return s;
   endfunction

   br_vec_t brTable[16];

   initial begin
      stim_t s;
      checks = 0;
      failures = 0;

      for (int i = 0; i < 8; i++) begin
         brTable[i].cond = 3'(i);
         brTable[i].flag_we = 1'b0;
         brTable[i].zout = 1'b0;
         brTable[i].clock_after = 1'b1;
         brTable[i + 8].cond = 3'(i);
         brTable[i + 8].flag_we = 1'b1;
         brTable[i + 8].zout = 1'b1;
         brTable[i + 8].clock_after = 1'b0;
      end
      // status {V=1,N=0,Z=0}: never, Z, !Z, N, !N, V, N^V, always
      brTable[0].exp_taken = 0; brTable[1].exp_taken = 0;
      brTable[2].exp_taken = 1; brTable[3].exp_taken = 0;
      brTable[4].exp_taken = 1; brTable[5].exp_taken = 1;
      brTable[6].exp_taken = 1; brTable[7].exp_taken = 1;
      for (int i = 0; i < 8; i++) brTable[i + 8].exp_taken = brTable[i].exp_taken;

      rst_n = 1'b0;
      applyStimulus(mk(0, 0, 0, 0, 0, 32'd0, 0));
      modelReset();
      #25;
      checkOutput("reset");
      rst_n = 1'b1;

      // Flag write with V blocked by ovf_en=0
      applyStimulus(mk(1, 1, 0, 1, 0, 32'h0000_1234, 0));
      cycle("flags");
      checkVal("flags.status_const", {29'd0, status}, 32'd1);
      checkVal("flags.cnt_const", {24'd0, ovf_cnt}, 32'd0);

      // Trap raise
      applyStimulus(mk(1, 0, 0, 1, 1, 32'h0040_0010, 0));
      #1;
      checkVal("trap.branch_pre", {31'd0, branch_taken}, 32'd1);
      cycle("trap.raise");
      applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 0));
      #1;
      checkVal("trap.req", {31'd0, trap_req}, 32'd1);
      checkVal("trap.epc", epc, 32'h0040_0010);
      checkVal("trap.branch_forced", {31'd0, branch_taken}, 32'd0);
      for (int i = 0; i < 5; i++) cycle("trap.hold");
      checkVal("trap.held", {31'd0, trap_req}, 32'd1);

      // Event while pending keeps epc, still counts
      applyStimulus(mk(1, 0, 0, 1, 1, 32'h0040_0020, 0));
      cycle("coll.evt");
      checkVal("coll.epc", epc, 32'h0040_0010);
      checkVal("coll.cnt2", {24'd0, ovf_cnt}, 32'd2);

      // Ack together with a new event
      applyStimulus(mk(1, 0, 0, 1, 1, 32'h0040_0030, 1));
      cycle("coll.ackevt");
      checkVal("coll.idle", {31'd0, trap_req}, 32'd0);
      checkVal("coll.cnt3", {24'd0, ovf_cnt}, 32'd3);
      checkVal("coll.epc_keep", epc, 32'h0040_0010);

      // Plain ack pulse
      applyStimulus(mk(1, 0, 0, 1, 1, 32'h0040_0040, 0));
      cycle("ack.raise");
      applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 1));
      cycle("ack.pulse");
      checkVal("ack.dropped", {31'd0, trap_req}, 32'd0);
      applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 0));

      // Branch condition table against status {V=1,N=0,Z=0}
      for (int i = 0; i < 16; i++) begin
         br_en = 1'b1;
         cond = brTable[i].cond;
         flag_we = brTable[i].flag_we;
         zout = brTable[i].zout;
         #1;
         checkVal($sformatf("br.cond%0d.we%0d", i % 8, brTable[i].flag_we),
                  {31'd0, branch_taken}, {31'd0, brTable[i].exp_taken});
         if (brTable[i].clock_after) cycle("br.step");
      end
      cycle("br.commit");
      checkVal("br.status_after", {29'd0, status}, 32'd1);

      // Randomized traffic
      for (int i = 0; i < 200; i++) begin
         s.flag_we  = ($urandom_range(0, 3) != 0);
         s.zout     = 1'($urandom);
         s.nout     = 1'($urandom);
         s.overflow = ($urandom_range(0, 2) == 0);
         s.ovf_en   = 1'($urandom);
         s.alu_sum  = $urandom;
         s.pc       = $urandom;
         s.br_en    = 1'($urandom);
         s.cond     = 3'($urandom);
         s.trap_ack = ($urandom_range(0, 2) == 0);
         applyStimulus(s);
         #1;
         checkVal("rand.branch_pre", {31'd0, branch_taken}, {31'd0, modelBranch()});
         cycle("rand");
      end

      // Saturation: event every cycle, trap acked each time
      applyStimulus(mk(1, 0, 1, 1, 1, 32'h0050_0000, 1));
      for (int i = 0; i < 300; i++) cycle("sat");
      checkVal("sat.cnt255", {24'd0, ovf_cnt}, 32'd255);
      for (int i = 0; i < 5; i++) cycle("sat.hold");
      checkVal("sat.cnt_hold", {24'd0, ovf_cnt}, 32'd255);

      // Async reset while a trap is pending
      applyStimulus(mk(1, 0, 1, 1, 1, 32'h0060_0000, 0));
      cycle("areset.pend");
      applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 0));
      checkVal("areset.pre_req", {31'd0, trap_req}, 32'd1);
      #4;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("areset");
      checkVal("areset.req0", {31'd0, trap_req}, 32'd0);
      checkVal("areset.cnt0", {24'd0, ovf_cnt}, 32'd0);
      #2;
      rst_n = 1'b1;
      cycle("areset.after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
